// File: rtl/spart_rx_if.sv
// Receive-side bus of the SPART: baud tick and serial line in, received byte and status out.
// Handshake: rda acts as "valid" for rx_data; a one-cycle rd_en strobe consumes it (ready/accept), and a new byte may overwrite an unconsumed one (overrun).
interface spart_rx_if;
  logic       rx_baud_en;
  logic       rxd;
  logic       rd_en;
  logic [7:0] rx_data;
  logic       rda;
  logic       framing_err;
  logic       overrun;
  logic [1:0] state_dbg;  // 0=IDLE 1=START 2=DATA 3=STOP

  modport master (
    output rx_baud_en, rxd, rd_en,
    input  rx_data, rda, framing_err, overrun, state_dbg
  );

  modport slave (
    input  rx_baud_en, rxd, rd_en,
    output rx_data, rda, framing_err, overrun, state_dbg
  );
endinterface

// File: rtl/spart_rx.sv
// 8N1 serial receiver with 16x oversampling, single-byte receive buffer and
// sticky framing/overrun status.
module spart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  spart_rx_if.slave bus
);

  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t     state, state_nxt;
  logic       rx_meta, rxs;
  logic [3:0] tick_cnt, tick_nxt;
  logic [2:0] bit_cnt, bit_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       load;

  // Both synchronizer flops reset high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.rx_baud_en) begin
      case (state)
        IDLE:  if (!rxs) state_nxt = START;
        START: if (tick_cnt == MID_TICK) state_nxt = rxs ? IDLE : DATA;
        DATA:  if (tick_cnt == LAST_TICK && bit_cnt == 3'd7) state_nxt = STOP;
        STOP:  if (tick_cnt == LAST_TICK) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    load      = 1'b0;
    if (bus.rx_baud_en) begin
      case (state)
        IDLE: tick_nxt = 4'd0;
        START: begin
          if (tick_cnt == MID_TICK) begin
            tick_nxt = 4'd0;
            bit_nxt  = 3'd0;
          end else begin
            tick_nxt = tick_cnt + 4'd1;
          end
        end
        DATA: begin
          if (tick_cnt == LAST_TICK) begin
            tick_nxt  = 4'd0;
            bit_nxt   = bit_cnt + 3'd1;
            shreg_nxt = {rxs, shreg[7:1]};
          end else begin
            tick_nxt = tick_cnt + 4'd1;
          end
        end
        STOP: begin
          if (tick_cnt == LAST_TICK) begin
            tick_nxt = 4'd0;
            load     = 1'b1;
          end else begin
            tick_nxt = tick_cnt + 4'd1;
          end
        end
        default: tick_nxt = 4'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
    end else begin
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= shreg_nxt;
    end
  end

  // A load beats a simultaneous read: the fresh byte stays available and
  // overrun clears because the old byte was consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rx_data     <= 8'h00;
      bus.rda         <= 1'b0;
      bus.framing_err <= 1'b0;
      bus.overrun     <= 1'b0;
    end else if (load) begin
      bus.rx_data     <= shreg;
      bus.rda         <= 1'b1;
      bus.framing_err <= ~rxs;
      bus.overrun     <= bus.rd_en ? 1'b0 : (bus.overrun | bus.rda);
    end else if (bus.rd_en) begin
      bus.rda     <= 1'b0;
      bus.overrun <= 1'b0;
    end
  end

  assign bus.state_dbg = state;

endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: drives 8N1 frames at 16 ticks/bit and checks the receive
// buffer and flags against a frame-level model.
module tb_spart_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  spart_rx_if bus ();

  spart_rx #(.OVERSAMPLE(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int gap = 1;

  logic [7:0] exp_q[$];
  logic [7:0] exp_data = 8'h00;
  logic       exp_rda = 1'b0;
  logic       exp_fe = 1'b0;
  logic       exp_ovr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One baud tick; gap is the spacing in clocks between tick pulses.
  task automatic tick(input logic rd);
    @(negedge clk);
    bus.rx_baud_en = 1'b1;
    bus.rd_en      = rd;
    @(posedge clk);
    #1;
    bus.rx_baud_en = 1'b0;
    bus.rd_en      = 1'b0;
    if (gap > 1) begin
      repeat (gap - 1) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_ticks(input int n);
    bus.rxd = 1'b1;
    repeat (n) tick(1'b0);
  endtask

  task automatic do_read();
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    exp_rda = 1'b0;
    exp_ovr = 1'b0;
  endtask

  // Start detection costs one tick of sync lag, two when ticks are back to back;
  // the stop bit is sampled 152 ticks after detection.
  function automatic int load_idx();
    return (gap == 1) ? 154 : 153;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_data"}, 32'(bus.rx_data), 32'(exp_data));
    check({tag, "_rda"}, 32'(bus.rda), 32'(exp_rda));
    check({tag, "_fe"}, 32'(bus.framing_err), 32'(exp_fe));
    check({tag, "_ovr"}, 32'(bus.overrun), 32'(exp_ovr));
  endtask

  task automatic send_frame(input string tag, input logic [7:0] b, input logic stop, input logic rd_at_load);
    logic [9:0] fr;
    logic [7:0] popped;
    int li;
    fr = {stop, b, 1'b0};
    li = load_idx();
    exp_q.push_back(b);
    for (int i = 0; i < 160; i++) begin
      bus.rxd = fr[i / 16];
      tick(rd_at_load && (i == li));
      if (i == li - 1) check({tag, "_preload_rda"}, 32'(bus.rda), 32'(exp_rda));
      if (i == li) begin
        check({tag, "_load_rda"}, 32'(bus.rda), 32'd1);
        check({tag, "_load_data"}, 32'(bus.rx_data), 32'(b));
      end
    end
    popped = exp_q.pop_front();
    exp_ovr  = rd_at_load ? 1'b0 : (exp_ovr | exp_rda);
    exp_rda  = 1'b1;
    exp_data = popped;
    exp_fe   = ~stop;
    idle_ticks(16);
    check_outputs(tag);
  endtask

  initial begin
    logic [9:0] fr;
    bus.rxd = 1'b1;
    bus.rx_baud_en = 1'b0;
    bus.rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset_state", 32'(bus.state_dbg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_ticks(4);

    // Single byte with exact load timing on back-to-back ticks
    gap = 1;
    send_frame("a5", 8'hA5, 1'b1, 1'b0);
    do_read();
    check_outputs("a5_read");

    // False start: 4 low ticks then high
    gap = 2;
    bus.rxd = 1'b0;
    repeat (4) tick(1'b0);
    idle_ticks(24);
    check("fstart_rda", 32'(bus.rda), 32'd0);
    check("fstart_state", 32'(bus.state_dbg), 32'd0);
    send_frame("3c", 8'h3C, 1'b1, 1'b0);
    do_read();

    // Framing error, then a good frame clears it
    send_frame("55fe", 8'h55, 1'b0, 1'b0);
    do_read();
    send_frame("12", 8'h12, 1'b1, 1'b0);
    do_read();

    // Overrun
    gap = 3;
    send_frame("11", 8'h11, 1'b1, 1'b0);
    send_frame("22ovr", 8'h22, 1'b1, 1'b0);
    do_read();
    check_outputs("ovr_read");

    // Read collides with load of second byte
    send_frame("66", 8'h66, 1'b1, 1'b0);
    send_frame("77col", 8'h77, 1'b1, 1'b1);
    do_read();

    // Reset mid-frame with a pending byte and overrun
    send_frame("r1", 8'h31, 1'b1, 1'b0);
    send_frame("r2", 8'h32, 1'b1, 1'b0);
    fr = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 70; i++) begin
      bus.rxd = fr[i / 16];
      tick(1'b0);
    end
    bus.rxd = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    exp_data = 8'h00; exp_rda = 1'b0; exp_fe = 1'b0; exp_ovr = 1'b0;
    check_outputs("rst_mid");
    check("rst_mid_state", 32'(bus.state_dbg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_ticks(100);
    check_outputs("rst_after");
    send_frame("c3", 8'hC3, 1'b1, 1'b0);
    do_read();

    // Randomized frames, spacing, stop bits, reads and collisions
    for (int k = 0; k < 24; k++) begin
      logic [7:0] b;
      logic stop;
      logic col;
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      col  = ($urandom_range(0, 5) == 0);
      gap  = $urandom_range(1, 4);
      send_frame($sformatf("rnd%0d", k), b, stop, col);
      if ($urandom_range(0, 1) == 1) do_read();
    end
    check("final_state", 32'(bus.state_dbg), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/spart_rx.md
SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning receive-baud ticks per serial bit; only 16 is supported.
REQ-002 SHALL have port clk, input, 1, system clock (50 MHz).
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port rx_baud_en, input, 1, one-cycle enable pulse at 16x baud from the baud generator's receive_baud output.
REQ-005 SHALL have port rxd, input, 1, asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-006 SHALL have port rd_en, input, 1, one-cycle host read strobe of the receive buffer.
REQ-007 SHALL have port rx_data, output, 8, receive buffer.
REQ-008 SHALL have port rda, output, 1, receive data available.
REQ-009 SHALL have port framing_err, output, 1, the stop bit of the last loaded byte sampled 0.
REQ-010 SHALL have port overrun, output, 1, sticky flag: a byte was loaded while rda was already 1.

Function
REQ-011 SHALL pass rxd through a 2-flop synchronizer whose flops reset to 1; all sampling SHALL use the synchronized value rxs.
REQ-012 SHALL implement a state machine with states IDLE, START, DATA and STOP, a 4-bit tick counter and a 3-bit bit counter.
REQ-013 SHALL change the state and both counters only in cycles where rx_baud_en=1, except on reset.
REQ-014 IDLE: on a tick with rxs=0, SHALL go to START with tick counter=0.
REQ-015 START: SHALL increment the tick counter on each tick.
REQ-016 START: on the tick where the counter equals 7 (mid start bit), SHALL go to DATA with counter=0 and bit counter=0 if rxs=0.
REQ-017 START: on that same tick, SHALL return to IDLE if rxs=1 (false start).
REQ-018 DATA: on the tick where the counter equals 15 (mid bit), SHALL right-shift rxs into an 8-bit shift register MSB so that the first bit lands in bit 0, reset the counter and increment the bit counter.
REQ-019 DATA: after the 8th sample (bit counter wraps 7->0), SHALL go to STOP.
REQ-020 STOP: on the tick where the counter equals 15, SHALL load rx_data from the shift register, set rda=1, set framing_err=~rxs and return to IDLE in the same tick.
REQ-021 SHALL make rda, rx_data and framing_err visible one clk after the mid-stop sampling tick, as registered outputs.
REQ-022 Load without rd_en: SHALL set overrun=1 if rda was 1 in that cycle; overrun SHALL otherwise be unchanged.
REQ-023 rd_en without load: SHALL clear rda and overrun; rx_data and framing_err SHALL hold.
REQ-024 rd_en and load in the same cycle: the load SHALL win, giving rda=1, new rx_data and overrun=0.
REQ-025 SHALL make rd_en with rda=0 a no-op apart from clearing overrun.
REQ-026 A frame with stop bit 0 SHALL still load data and assert rda; the receiver SHALL re-arm in IDLE, and a held-low line SHALL start a new frame on the next tick.
REQ-027 SHALL neither drop nor duplicate samples when rx_baud_en is asserted on back-to-back cycles.

Reset
REQ-028 On rst_n=0, SHALL immediately reset: state IDLE, counters 0, shift register 0x00, rx_data=0x00, rda=0, framing_err=0, overrun=0, synchronizer flops=1.
REQ-029 SHALL discard any partially received frame on reset assertion mid-frame; no load SHALL occur.
REQ-030 After release, SHALL require a fresh falling edge on rxs plus a valid start bit before any reception.

Verification
REQ-031 Reset: drive rxd=1 and pulse rst_n low mid-frame -> all outputs 0 and state IDLE; no rda for the rest of that frame.
REQ-032 Single byte: send 0xA5 with a good stop bit at 16 ticks/bit -> rx_data=0xA5, rda=1, framing_err=0 one clk after the stop-bit tick 8; rd_en -> rda=0 and rx_data stays 0xA5.
REQ-033 False start: drive rxd low for 4 ticks, then high -> returns to IDLE; rda stays 0; a subsequent 0x3C frame is received correctly.
REQ-034 Framing error: send 0x55 with stop bit 0 -> rx_data=0x55, rda=1, framing_err=1; the next good frame 0x12 -> framing_err=0.
REQ-035 Overrun: send 0x11 then 0x22 with no rd_en -> rx_data=0x22, rda=1, overrun=1; rd_en -> rda=0, overrun=0.
REQ-036 Read collision: assert rd_en in exactly the load cycle of the second byte 0x77 -> rda=1, rx_data=0x77, overrun=0.
